// File: rtl/key_pla_pkg.sv
// Shared definitions for the keyboard scan/debounce decode.
//   key_state_e : 2-bit debounce state {keyQ1,keyQ0}
//   STB_OFF     : inactive level of the active-low latch strobes
//   key_dec_t   : one decode result (next state + both strobes)
//   key_decode  : the next-state/strobe table, a pure function
package key_pla_pkg;

  typedef enum logic [1:0] {
    KEY_S0 = 2'b00,  // idle
    KEY_S1 = 2'b01,  // first detect
    KEY_S2 = 2'b10,  // key accepted / held
    KEY_S3 = 2'b11   // release candidate
  } key_state_e;

  localparam logic STB_OFF = 1'b1;

  typedef struct packed {
    key_state_e nxt;
    logic       n_ld_comp;
    logic       n_ld_kbus;
  } key_dec_t;

  localparam key_dec_t DEC_IDLE = '{nxt: KEY_S0, n_ld_comp: STB_OFF, n_ld_kbus: STB_OFF};

  // kr  = key pressed at current scan address
  // cmp = scan code matches the compare latch
  function automatic key_dec_t key_decode(key_state_e cur, logic kr, logic cmp);
    key_dec_t r;
    r.nxt       = cur;
    r.n_ld_comp = STB_OFF;
    r.n_ld_kbus = STB_OFF;
    unique case (cur)
      KEY_S0: if (kr) begin
        r.nxt       = KEY_S1;
        r.n_ld_comp = 1'b0;   // capture this scan code for the debounce compare
      end
      KEY_S1: begin
        if (kr && cmp) begin
          r.nxt       = KEY_S2;
          r.n_ld_kbus = 1'b0; // second sighting of the same key: publish it
        end else if (kr != cmp) begin
          r.nxt = KEY_S0;     // another key pressed, or same key bounced away
        end
      end
      KEY_S2: if (!kr && cmp) r.nxt = KEY_S3;
      KEY_S3: if (cmp) r.nxt = kr ? KEY_S2 : KEY_S0;  // bounce returns without reload
      default: r = DEC_IDLE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/key_pla_if.sv
// Signal bundle between the keyboard scan section and the debounce decode.
//   master : scan logic side, drives state/return/match, receives decode
//   slave  : key_pla side
interface key_pla_if;
  logic iKR1;
  logic keyQ0;
  logic keyQ1;
  logic debComp;
  logic keyD0;
  logic keyD1;
  logic nLdComp;
  logic nLdKbus;

  modport master (output iKR1, keyQ0, keyQ1, debComp,
                  input  keyD0, keyD1, nLdComp, nLdKbus);
  modport slave  (input  iKR1, keyQ0, keyQ1, debComp,
                  output keyD0, keyD1, nLdComp, nLdKbus);
endinterface

// File: rtl/key_pla.sv
// Next-state and strobe decode for the keyboard scan/debounce machine.
// The state register itself lives outside this block.
//   clk     : capture clock, only meaningful when REG_OUT=1
//   reset   : async, active high; forces next=S0 and strobes inactive
//   kif     : slave side of key_pla_if (iKR1/keyQ1/keyQ0/debComp in,
//             keyD1/keyD0/nLdComp/nLdKbus out)
// REG_OUT=0: outputs combinational; REG_OUT=1: outputs registered on clk.
module key_pla
  import key_pla_pkg::*;
#(
  parameter bit REG_OUT = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  key_pla_if.slave   kif
);

  key_dec_t dec_d, dec_q, dec_o;

  always_comb
    dec_d = key_decode(key_state_e'({kif.keyQ1, kif.keyQ0}), kif.iKR1, kif.debComp);

  // Output register; left unused (and trimmed) when REG_OUT=0.
  always_ff @(posedge clk or posedge reset)
    if (reset) dec_q <= DEC_IDLE;
    else       dec_q <= dec_d;

  always_comb begin
    dec_o = DEC_IDLE;
    if (REG_OUT)     dec_o = dec_q;
    else if (!reset) dec_o = dec_d;
  end

  assign kif.keyD1   = dec_o.nxt[1];
  assign kif.keyD0   = dec_o.nxt[0];
  assign kif.nLdComp = dec_o.n_ld_comp;
  assign kif.nLdKbus = dec_o.n_ld_kbus;

endmodule

// File: tb/tb_key_pla.sv
module tb_key_pla;

  logic clk = 1'b0;
  logic rst0, rst1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  key_pla_if kif0 ();
  key_pla_if kif1 ();

  key_pla #(.REG_OUT(1'b0)) dut0 (.clk(clk), .reset(rst0), .kif(kif0));
  key_pla #(.REG_OUT(1'b1)) dut1 (.clk(clk), .reset(rst1), .kif(kif1));

  function automatic logic [3:0] obs0();
    return {kif0.keyD1, kif0.keyD0, kif0.nLdComp, kif0.nLdKbus};
  endfunction
  function automatic logic [3:0] obs1();
    return {kif1.keyD1, kif1.keyD0, kif1.nLdComp, kif1.nLdKbus};
  endfunction

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // closed-loop state register model for dut0
  logic [1:0] st;
  int comp_pulses, kbus_pulses;

  task automatic step(input string tag, input logic kr, input logic dc,
                      input logic [1:0] exp_nxt, input logic exp_c, input logic exp_k);
    logic [3:0] o;
    kif0.iKR1 = kr; kif0.debComp = dc; {kif0.keyQ1, kif0.keyQ0} = st;
    #1;
    o = obs0();
    chk(tag, o, {exp_nxt, exp_c, exp_k});
    if (!o[1]) comp_pulses++;
    if (!o[0]) kbus_pulses++;
    @(posedge clk);
    st = o[3:2];
    @(negedge clk);
  endtask

  // {debComp,keyQ1,keyQ0,iKR1} -> {keyD1,keyD0,nLdComp,nLdKbus}
  logic [3:0] exp_tab [16];

  initial begin
    exp_tab = '{4'b0011, 4'b0101, 4'b0111, 4'b0011,
                4'b1011, 4'b1011, 4'b1111, 4'b1111,
                4'b0011, 4'b0101, 4'b0011, 4'b1010,
                4'b1111, 4'b1011, 4'b0011, 4'b1011};

    rst0 = 1'b0; rst1 = 1'b1;
    {kif0.debComp, kif0.keyQ1, kif0.keyQ0, kif0.iKR1} = 4'b0000;
    {kif1.debComp, kif1.keyQ1, kif1.keyQ0, kif1.iKR1} = 4'b0000;
    #1;
    chk("reg_reset_state", obs1(), 4'b0011);

    // combinational truth-table sweep
    for (int i = 0; i < 16; i++) begin
      {kif0.debComp, kif0.keyQ1, kif0.keyQ0, kif0.iKR1} = 4'(i);
      #5;
      chk($sformatf("sweep_%b", 4'(i)), obs0(), exp_tab[i]);
    end

    // async reset on combinational variant
    {kif0.debComp, kif0.keyQ1, kif0.keyQ0, kif0.iKR1} = 4'b1001;
    rst0 = 1'b1; #1;
    chk("comb_reset_forced", obs0(), 4'b0011);
    rst0 = 1'b0; #1;
    chk("comb_reset_release", obs0(), 4'b0101);

    // registered variant: release reset away from the edge
    @(negedge clk);
    rst1 = 1'b0;
    {kif1.debComp, kif1.keyQ1, kif1.keyQ0, kif1.iKR1} = 4'b1011;
    #1;
    chk("reg_before_edge", obs1(), 4'b0011);
    @(posedge clk); #1;
    chk("reg_after_edge", obs1(), 4'b1010);
    // reset pulse mid-cycle
    @(negedge clk);
    rst1 = 1'b1; #1;
    chk("reg_async_reset", obs1(), 4'b0011);
    @(posedge clk); #1;
    chk("reg_held_in_reset", obs1(), 4'b0011);
    @(negedge clk);
    rst1 = 1'b0; #1;
    chk("reg_no_capture_yet", obs1(), 4'b0011);
    @(posedge clk); #1;
    chk("reg_first_capture", obs1(), 4'b1010);

    // closed-loop press/release through dut0
    @(negedge clk);
    st = 2'b00; comp_pulses = 0; kbus_pulses = 0;
    step("loop_press",   1'b1, 1'b0, 2'b01, 1'b0, 1'b1);
    step("loop_confirm", 1'b1, 1'b1, 2'b10, 1'b1, 1'b0);
    step("loop_hold",    1'b1, 1'b1, 2'b10, 1'b1, 1'b1);
    step("loop_release", 1'b0, 1'b1, 2'b11, 1'b1, 1'b1);
    step("loop_idle",    1'b0, 1'b1, 2'b00, 1'b1, 1'b1);
    chk("loop_end_state", {st, 2'b00}, 4'b0000);
    chk_int("loop_comp_pulses", comp_pulses, 1);
    chk_int("loop_kbus_pulses", kbus_pulses, 1);

    // bounce in S3 returns to S2 without reloading KBCODE
    comp_pulses = 0; kbus_pulses = 0;
    step("bnc_press",    1'b1, 1'b0, 2'b01, 1'b0, 1'b1);
    step("bnc_confirm",  1'b1, 1'b1, 2'b10, 1'b1, 1'b0);
    step("bnc_release",  1'b0, 1'b1, 2'b11, 1'b1, 1'b1);
    step("bnc_bounce",   1'b1, 1'b1, 2'b10, 1'b1, 1'b1);
    step("bnc_release2", 1'b0, 1'b1, 2'b11, 1'b1, 1'b1);
    step("bnc_idle",     1'b0, 1'b1, 2'b00, 1'b1, 1'b1);
    chk_int("bnc_comp_pulses", comp_pulses, 1);
    chk_int("bnc_kbus_pulses", kbus_pulses, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
